// File: rtl/reflet_pipelined_multiplier_if.sv
// Request/result bundle for the pipelined multiplier.
// The master side drives operands and stall control; the slave side returns the product.
interface reflet_pipelined_multiplier_if #(
    parameter int size = 16
);
    logic                enable;
    logic                in_valid;
    logic                in_signed;
    logic [size-1:0]     in_1;
    logic [size-1:0]     in_2;
    logic                out_valid;
    logic [2*size-1:0]   out;
    logic                busy;

    modport master (
        output enable, in_valid, in_signed, in_1, in_2,
        input  out_valid, out, busy
    );

    modport slave (
        input  enable, in_valid, in_signed, in_1, in_2,
        output out_valid, out, busy
    );
endinterface

// File: rtl/reflet_pipelined_multiplier.sv
// Fully pipelined size x size multiplier with a per-request signed/unsigned selection.
// Each level retires bits_per_stage multiplier bits; the last level writes the product straight into out.
module reflet_pipelined_multiplier #(
    parameter int size           = 16,
    parameter int bits_per_stage = 1
) (
    input logic                         clk,
    input logic                         reset,
    reflet_pipelined_multiplier_if.slave bus
);
    localparam int stages = size / bits_per_stage;
    localparam int w      = 2 * size;
    localparam int pipe_n = (stages > 1) ? stages - 1 : 1;

    if (bits_per_stage < 1 || size < 2 || (size % bits_per_stage) != 0) begin : g_param_check
        $error("reflet_pipelined_multiplier: bits_per_stage must divide size and size must be >= 2");
    end

    typedef struct packed {
        logic            valid;
        logic            sgn;
        logic [w-1:0]    acc;
        logic [w-1:0]    mcand;
        logic [size-1:0] mult;
    } slot_t;

    slot_t        pipe_q [pipe_n];
    slot_t        pipe_d [pipe_n];
    logic [w-1:0] out_q;
    logic         out_valid_q;
    logic [w-1:0] ret_acc;
    logic         ret_valid;
    logic         busy_c;

    // The top multiplier bit has negative weight in signed mode, so its partial product is subtracted.
    function automatic logic [w-1:0] add_digit(
        input logic [w-1:0]              acc,
        input logic [w-1:0]              mcand,
        input logic [bits_per_stage-1:0] digit,
        input logic                      neg_top
    );
        logic [w-1:0] sum;
        logic [w-1:0] term;
        sum = acc;
        for (int j = 0; j < bits_per_stage; j++) begin
            term = mcand << j;
            if (digit[j]) begin
                if (neg_top && j == bits_per_stage - 1)
                    sum = sum - term;
                else
                    sum = sum + term;
            end
        end
        return sum;
    endfunction

    always_comb begin
        slot_t cur;
        cur.valid = bus.in_valid;
        cur.sgn   = bus.in_signed;
        cur.acc   = '0;
        cur.mcand = bus.in_signed ? {{size{bus.in_1[size-1]}}, bus.in_1}
                                  : {{size{1'b0}}, bus.in_1};
        cur.mult  = bus.in_2;
        ret_acc   = '0;
        ret_valid = 1'b0;
        for (int i = 0; i < pipe_n; i++)
            pipe_d[i] = '0;
        for (int k = 0; k < stages; k++) begin
            if (k > 0)
                cur = pipe_q[(k > 0) ? k - 1 : 0];
            cur.acc   = add_digit(cur.acc, cur.mcand, cur.mult[bits_per_stage-1:0],
                                  cur.sgn && (k == stages - 1));
            cur.mcand = cur.mcand << bits_per_stage;
            cur.mult  = cur.mult >> bits_per_stage;
            if (k < stages - 1) begin
                pipe_d[k] = cur;
            end else begin
                ret_acc   = cur.acc;
                ret_valid = cur.valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < pipe_n; i++)
                pipe_q[i].valid <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (bus.enable) begin
            for (int i = 0; i < pipe_n; i++)
                pipe_q[i] <= pipe_d[i];
            out_valid_q <= ret_valid;
            if (ret_valid)
                out_q <= ret_acc;
        end
    end

    always_comb begin
        busy_c = out_valid_q;
        for (int i = 0; i < pipe_n; i++)
            busy_c = busy_c | pipe_q[i].valid;
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_c;
endmodule

// File: tb/tb_reflet_pipelined_multiplier.sv
// Drives six multiplier configurations with shared stimulus and scoreboards each against
// a plain-arithmetic reference product expected after `stages` enabled edges.
module tb_reflet_pipelined_multiplier;
    localparam int NCFG = 6;

    function automatic int cfg_size(int g);
        return (g < 4) ? 8 : 16;
    endfunction

    function automatic int cfg_bps(int g);
        case (g)
            0: return 1;
            1: return 2;
            2: return 4;
            3: return 8;
            4: return 1;
            default: return 4;
        endcase
    endfunction

    typedef struct packed {
        logic [31:0] val;
        int          due;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst, en, iv, isg;
    logic [15:0] ia, ib;
    logic        use8;
    logic [15:0] e8;

    logic        ov [NCFG];
    logic [31:0] ot [NCFG];
    logic        bz [NCFG];

    sb_t         sb [NCFG][$];
    logic        exp_ov  [NCFG];
    logic [31:0] exp_out [NCFG];
    int          en_cnt    = 0;
    int          edge_kind = 0;   // 0 reset edge, 1 enabled edge, 2 stalled edge
    int          n_cmp     = 0;
    int          n_bad     = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam int SZ  = cfg_size(g);
        localparam int BPS = cfg_bps(g);
        reflet_pipelined_multiplier_if #(.size(SZ)) bus ();
        reflet_pipelined_multiplier #(.size(SZ), .bits_per_stage(BPS)) dut (
            .clk   (clk),
            .reset (rst),
            .bus   (bus)
        );
        assign bus.enable    = en;
        assign bus.in_valid  = iv;
        assign bus.in_signed = isg;
        assign bus.in_1      = ia[SZ-1:0];
        assign bus.in_2      = ib[SZ-1:0];
        assign ov[g] = bus.out_valid;
        assign ot[g] = 32'(bus.out);
        assign bz[g] = bus.busy;
    end

    function automatic logic [31:0] ref_mul(logic [15:0] a, logic [15:0] b, bit sgn, int sz);
        longint m, x, y, p;
        m = (longint'(1) << sz) - 1;
        x = longint'(a) & m;
        y = longint'(b) & m;
        if (sgn && x[sz-1]) x = x - (longint'(1) << sz);
        if (sgn && y[sz-1]) y = y - (longint'(1) << sz);
        p = x * y;
        p = p & ((longint'(1) << (2 * sz)) - 1);
        return p[31:0];
    endfunction

    task automatic chk(string name, int g, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cfg%0d (size %0d bps %0d) got %h expected %h at %0t",
                     name, g, cfg_size(g), cfg_bps(g), act, exp, $time);
        end
    endtask

    // Issue side: classify each edge and record accepted operations with their due edge.
    always @(posedge clk) begin
        if (rst) begin
            edge_kind = 0;
            for (int g = 0; g < NCFG; g++) sb[g].delete();
        end else if (en) begin
            edge_kind = 1;
            en_cnt++;
            if (iv) begin
                for (int g = 0; g < NCFG; g++) begin
                    sb_t e;
                    e.due = en_cnt + cfg_size(g) / cfg_bps(g) - 1;
                    e.val = (use8 && g < 4) ? {16'h0, e8} : ref_mul(ia, ib, isg, cfg_size(g));
                    sb[g].push_back(e);
                end
            end
        end else begin
            edge_kind = 2;
        end
    end

    // Monitor: retire whatever is due on this edge and compare the visible outputs.
    always @(negedge clk) begin
        for (int g = 0; g < NCFG; g++) begin
            if (edge_kind == 0) begin
                exp_ov[g]  = 1'b0;
                exp_out[g] = '0;
            end else if (edge_kind == 1) begin
                if (sb[g].size() > 0 && sb[g][0].due == en_cnt) begin
                    sb_t e;
                    e = sb[g].pop_front();
                    exp_ov[g]  = 1'b1;
                    exp_out[g] = e.val;
                end else begin
                    exp_ov[g] = 1'b0;
                end
            end
            chk("out_valid", g, {31'b0, ov[g]}, {31'b0, exp_ov[g]});
            chk("out", g, ot[g], exp_out[g]);
            chk("busy", g, {31'b0, bz[g]}, {31'b0, exp_ov[g] || (sb[g].size() > 0)});
        end
    end

    task automatic step(bit r, bit e, bit v, bit s, logic [15:0] a, logic [15:0] b,
                        bit u8 = 1'b0, logic [15:0] x8 = 16'h0);
        rst = r; en = e; iv = v; isg = s; ia = a; ib = b; use8 = u8; e8 = x8;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        idle(2);

        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h00FF, 16'h00FF, 1'b1, 16'hFE01);
        idle(10);

        step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0080, 16'h0080, 1'b1, 16'h4000);
        step(1'b0, 1'b1, 1'b1, 1'b1, 16'h00FF, 16'h0001, 1'b1, 16'hFFFF);
        step(1'b0, 1'b1, 1'b1, 1'b1, 16'h007F, 16'h0080, 1'b1, 16'hC080);
        idle(10);

        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 1'b1, i[0], 16'h00FF, 16'h00FF, 1'b1, i[0] ? 16'h0001 : 16'hFE01);
        idle(10);

        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0003, 16'h0005, 1'b1, 16'h000F);
        idle(2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0011, 16'h0011);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        idle(12);

        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0009, 16'h0009);
        step(1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFE, 16'h0003);
        idle(20);

        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 99) < 85),
                 1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 1)),
                 16'($urandom), 16'($urandom));
        end
        idle(20);

        for (int g = 0; g < NCFG; g++)
            chk("leftover", g, 32'(sb[g].size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/reflet_pipelined_multiplier.md
# reflet_pipelined_multiplier

Parametrised, fully pipelined integer multiplier producing the exact 2×`size`-bit product of two `size`-bit operands, with per-request signed/unsigned selection. It retires `bits_per_stage` multiplier bits per pipeline stage, accepts one operation per enabled cycle, and tags each result with a valid flag. It replaces the fixed one-bit-per-cycle unsigned multiplier in the GPU arithmetic path and adds reset, stall and valid tracking.

## Interface
- `size`, 16, operand width in bits; ≥ 2.
- `bits_per_stage`, 1, multiplier bits consumed per stage; must divide `size`. Derived: `stages` = `size`/`bits_per_stage`.
- `clk`  input  1  sole clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high; clears all valid flags and `out`.
- `enable`  input  1  pipeline advance; low freezes every stage, including valid flags and `out`.
- `in_valid`  input  1  operands present this cycle; sampled only when `enable` is high.
- `in_signed`  input  1  1 = both operands two's complement, 0 = both unsigned; travels with the operation.
- `in_1`  input  `size`  multiplicand.
- `in_2`  input  `size`  multiplier.
- `out_valid`  output  1  `out` holds a newly retired product this cycle.
- `out`  output  2×`size`  registered product.
- `busy`  output  1  OR of all in-flight valid flags and `out_valid`.

## Operation
- Each stage register holds: valid flag, signed flag, accumulated partial sum (2×`size`), shifted multiplicand (2×`size`), remaining multiplier bits.
- Multiplicand entering stage 0 is extended to 2×`size`: sign-extended if `in_signed`, zero-extended otherwise.
- Stage k adds `A_ext << (k·bits_per_stage + j)` for each set multiplier bit j in its digit; all arithmetic modulo 2^(2×`size`).
- In signed mode, bit `size`-1 of `in_2` carries weight −2^(`size`-1): the last stage subtracts that partial product instead of adding it. Unsigned mode adds it.
- Result is exact for all inputs: no overflow, no saturation. Signed −2^(`size`-1) × −2^(`size`-1) = +2^(2·`size`-2).
- Slots with valid = 0 propagate but carry don't-care data. `out` updates only when a valid slot retires from the last stage; otherwise `out` holds its last value and `out_valid` = 0.
- `enable` low: no register changes, and the `in_valid` presented that cycle is dropped. `out_valid` keeps its current value, so a stalled result stays visible until the next enabled edge.
- `reset` high: every valid flag → 0, `out` → 0, `out_valid` → 0 at the next edge regardless of `enable`. In-flight operations are discarded and never appear at `out`. Datapath registers other than `out` need not be reset.
- Parameter check: elaboration fails (`$error` / generate guard) if `size` mod `bits_per_stage` ≠ 0.

## Timing
- Reset values: `out` = 0, `out_valid` = 0, `busy` = 0.
- Latency: an operation sampled at enabled edge E appears on `out` with `out_valid` = 1 after enabled edge E + `stages` − 1 (`stages` enabled edges including the sampling edge). Disabled cycles add to latency one for one.
- Throughput: one operation per enabled cycle, with no bubbles between back-to-back requests. Signed and unsigned requests may interleave freely.
- `out_valid` is high for exactly one enabled cycle per retired operation. It remains high through following disabled cycles.
- Simultaneous `reset` and `in_valid`: reset wins and the operation is dropped.
- Deasserting `reset` with `in_valid` high on the next enabled cycle: that operation is accepted normally.

## Test plan
- `size`=8, `bits_per_stage`=1, unsigned: 255×255 at edge 1 → `out` = 0xFE01 and `out_valid` = 1 after the 8th enabled edge. No `out_valid` before that.
- Signed, `size`=8: −128×−128 → 0x4000; −1×1 (0xFF×0x01) → 0xFFFF; 127×−128 → 0xC080. Back-to-back on consecutive cycles, retiring on consecutive cycles in order.
- Mixed mode on same operands 0xFF×0xFF: unsigned → 0xFE01, signed → 0x0001. Issued alternately with the flag carried through the pipeline.
- Stall: issue 3×5, hold `enable` low for 4 cycles mid-flight → result 15 arrives 4 cycles later. `out`/`out_valid` frozen during the stall; the `in_valid` pulse issued while stalled is never retired.
- Reset mid-flight: issue 4 operations, assert `reset` one cycle after the last → `out` = 0, `out_valid` = 0, `busy` = 0 next edge. None of the 4 results ever appear.
- Random sweep for `bits_per_stage` ∈ {1, 2, 4, 8} at `size`=8 and {1, 4} at `size`=16, including bubbles → every result matches a reference multiply, in order, at latency `stages`.
